// File: rtl/err_pattern_gen.sv
// Error-pattern generator: places exactly min(weight, DataW) ones at LFSR-chosen
// positions. Each PLACE cycle draws one candidate and rejects duplicates and out-of-range indices.
module err_pattern_gen #(
   parameter int unsigned DataW       = 2304,
   parameter int unsigned CountW      = 12,
   parameter int unsigned IdxW        = 12,
   parameter logic [15:0] DefaultSeed = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [CountW-1:0] weight_i,
   input  logic [15:0]       seed_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DataW-1:0]  err_vec_o,
   output logic [16:0]       attempts_o
);

   localparam int unsigned LfsrW = 16;
   localparam int unsigned AttW  = 17;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLACE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e             state_q;
   logic [LfsrW-1:0]   lfsr_q;
   logic [CountW-1:0]  remaining_q;
   logic [DataW-1:0]   err_vec_q;
   logic [AttW-1:0]    attempts_q;
   logic               busy_q;
   logic               done_q;

   logic [CountW-1:0]  weight_sat;
   logic [LfsrW-1:0]   seed_load;
   logic [IdxW-1:0]    cand;
   logic               cand_in_range;
   logic               accept;
   logic               lfsr_fb;
   logic [LfsrW-1:0]   lfsr_step;

   // Requested weight clamps to the pattern width.
   assign weight_sat = (weight_i > CountW'(DataW)) ? CountW'(DataW) : weight_i;
   assign seed_load  = (seed_i == '0) ? DefaultSeed : seed_i;

   // x^16+x^14+x^13+x^11+1, shifting left; a nonzero state never maps to zero.
   assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign lfsr_step = {lfsr_q[LfsrW-2:0], lfsr_fb};

   assign cand          = lfsr_q[IdxW-1:0];
   assign cand_in_range = (32'(cand) < DataW);
   assign accept        = cand_in_range && !err_vec_q[cand];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         lfsr_q      <= DefaultSeed;
         remaining_q <= '0;
         err_vec_q   <= '0;
         attempts_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               if (start_i) begin
                  err_vec_q   <= '0;
                  attempts_q  <= '0;
                  remaining_q <= weight_sat;
                  lfsr_q      <= seed_load;
                  if (weight_sat == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_PLACE;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_PLACE: begin
               lfsr_q <= lfsr_step;
               if (attempts_q != '1) begin
                  attempts_q <= attempts_q + AttW'(1);
               end
               if (accept) begin
                  err_vec_q[cand] <= 1'b1;
                  remaining_q     <= remaining_q - CountW'(1);
                  if (remaining_q == CountW'(1)) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_vec_o  = err_vec_q;
   assign attempts_o = attempts_q;

endmodule

// File: doc/err_pattern_gen.md
Name: err_pattern_gen

Overview:
- Generates a data_w-bit error pattern containing exactly the requested number of ones, at pseudo-random positions.
- Used as the channel error injector in the LDPC decoder test datapath.
- It is the inverse of the bit counter: the counter maps a vector to its weight, while this block maps a weight to a vector.
- The popcount of err_vec always equals min(weight, data_w), so the existing bit counter checks this block directly.

Parameters:
- data_w, 2304, pattern width in bits.
- count_w, 12, width of the weight input. Must satisfy 2^count_w > data_w.
- idx_w, 12, width of the candidate bit index. Must satisfy 2^idx_w >= data_w, and idx_w <= 16.
- default_seed, 16'hACE1, LFSR seed used when the seed input is zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new pattern. Sampled only in IDLE.
- weight  in  count_w  number of ones to place. Captured when start is accepted.
- seed  in  16  LFSR seed. Captured when start is accepted.
- busy  out  1  high while a pattern is being built.
- done  out  1  one-cycle pulse when the pattern is complete.
- err_vec  out  data_w  generated pattern. Held stable from done until the next accepted start.
- attempts  out  17  candidate draws used for the last pattern, saturating at 17'h1FFFF.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, busy=0, done=0, err_vec=0, attempts=0, remaining=0.
  - LFSR loaded with default_seed.
  - Reset mid-operation abandons the pattern; no done pulse is produced.
- States: IDLE, PLACE, DONE.
- IDLE:
  - start=1 at edge T accepts the request.
  - Also at edge T: err_vec cleared, attempts cleared, remaining = min(weight, data_w).
  - Also at edge T: LFSR loaded with seed, or with default_seed if seed==0.
  - If remaining==0, next state is DONE; otherwise PLACE.
  - busy=1 from T+1.
- PLACE, one candidate per cycle:
  - cand = lfsr[idx_w-1:0].
  - accept = (cand < data_w) && !err_vec[cand].
  - On accept: err_vec[cand] set to 1, remaining decremented.
  - LFSR always advances one step. attempts increments, saturating.
  - When the accepting edge makes remaining==0, next state is DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - For weight=0, done is high during cycle T+1 and err_vec=0.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting left.
  - Feedback bit = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
  - It is maximal length, so every idx_w-bit value recurs within 65535 steps. Each placement therefore terminates, even at weight=data_w.
- Latency:
  - Minimum latency is weight+1 cycles from start to done.
  - Rejections from out-of-range or duplicate candidates add one cycle each.
- Boundary conditions:
  - weight > data_w saturates to data_w.
  - start while busy or in DONE is ignored and does not queue.
  - start held high: a new request is accepted on the first IDLE cycle after done. err_vec is cleared at that edge.
  - Candidate index 0 and index data_w-1 must both be reachable.
  - The LFSR never becomes zero: a zero seed is replaced, and the update cannot reach zero.
- Outputs are registered. err_vec is never partially updated outside PLACE.

Test Plan:
- Reset check: assert rst_n=0 mid-PLACE with weight=100.
  - All outputs 0 immediately.
  - No done pulse after release.
  - The next start with weight=5 completes with popcount(err_vec)=5.
- weight=0, seed=16'h1234: done one cycle after start, err_vec all zero, attempts=0.
- weight=1, seed=16'h0001: done after accept. popcount=1; set bit index equals the first in-range LFSR value (reference model); attempts matches the reference model.
- weight=50, seed=16'hBEEF, repeated twice:
  - Bit-exact identical err_vec both runs.
  - popcount=50 via the bit counter.
  - done latency = attempts+1.
  - busy is high for exactly attempts cycles.
- weight=4095, seed=0:
  - Saturates to 2304; err_vec all ones.
  - Completes before 65536 attempts.
  - default_seed used (matches the model seeded with 16'hACE1).
- start pulsed during PLACE and during DONE with weight=7 (original weight=20):
  - Both pulses ignored; popcount=20.
  - With start held high, the next pattern begins on the cycle after done.
